// File: rtl/lagarto_v_pkg.sv
// lagarto_v_pkg: shared opcode constants, vector queue entry type and vector-class filter
package lagarto_v_pkg;
  localparam logic [6:0] OPC_OP_V     = 7'b1010111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam int VQ_ILEN = 32;
  localparam int VQ_XLEN = 64;
  typedef struct packed {
    logic [VQ_ILEN-1:0] inst;
    logic [VQ_XLEN-1:0] rs1_data;
    logic [2:0]         vsew;
  } vq_entry_t;
  function automatic logic is_vector_op(input logic [VQ_ILEN-1:0] inst);
    return inst[6:0] == OPC_OP_V || inst[6:0] == OPC_LOAD_FP || inst[6:0] == OPC_STORE_FP;
  endfunction
endpackage

// File: rtl/vq_fifo.sv
// vq_fifo: synchronous FIFO of vq_entry_t; ports clk_i/rstn_i (async low), flush_i, push_i, pop_i, din_i, dout_o, count_o, full_o, empty_o
module vq_fifo
  import lagarto_v_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  vq_entry_t              din_i,
  output vq_entry_t              dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  vq_entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic wr, rd;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign empty_o = count_o == '0;
  assign wr = push_i && !full_o && !flush_i;
  assign rd = pop_i && !empty_o && !flush_i;
  assign dout_o = mem[head];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      head    <= tail;
      count_o <= '0;
    end else begin
      if (wr) mem[tail] <= din_i;
      if (wr) tail <= tail + 1'b1;
      if (rd) head <= head + 1'b1;
      count_o <= count_o + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/vector_issue_queue.sv
// vector_issue_queue: vector-class filter + FIFO between scalar core and vector datapath.
// Ports: clk_i, rstn_i (async low), flush_i; inst_valid_i/inst_i/rs1_data_i/vsew_i/inst_ready_o in;
// vinst_valid_o/vinst_o/vrs1_data_o/vsew_o/vinst_ready_i out; count_o, issued_cnt_o, dropped_cnt_o.
// Define VIQ_BYPASS_EN for zero-latency pass-through when the queue is empty.
module vector_issue_queue
  import lagarto_v_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   inst_valid_i,
  input  logic [ILEN-1:0]        inst_i,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [2:0]             vsew_i,
  output logic                   inst_ready_o,
  output logic                   vinst_valid_o,
  output logic [ILEN-1:0]        vinst_o,
  output logic [XLEN-1:0]        vrs1_data_o,
  output logic [2:0]             vsew_o,
  input  logic                   vinst_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [CNT_W-1:0]       issued_cnt_o,
  output logic [CNT_W-1:0]       dropped_cnt_o
);
  vq_entry_t din, head;
  logic full, empty, acc, isv, byp, push;
  assign din = '{inst: inst_i, rs1_data: rs1_data_i, vsew: vsew_i};
  assign inst_ready_o = !full && rstn_i;
  assign acc = inst_valid_i && inst_ready_o;
  assign isv = is_vector_op(inst_i);
`ifdef VIQ_BYPASS_EN
  assign byp = empty && !flush_i && acc && isv;
`else
  assign byp = 1'b0;
`endif
  // a bypassed entry consumed in the same cycle never occupies storage
  assign push = acc && isv && !(byp && vinst_ready_i);
  assign vinst_valid_o = !empty || byp;
  assign vinst_o     = byp ? inst_i     : head.inst;
  assign vrs1_data_o = byp ? rs1_data_i : head.rs1_data;
  assign vsew_o      = byp ? vsew_i     : head.vsew;
  vq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .flush_i(flush_i),
    .push_i (push),
    .pop_i  (vinst_ready_i),
    .din_i  (din),
    .dout_o (head),
    .count_o(count_o),
    .full_o (full),
    .empty_o(empty)
  );
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      issued_cnt_o  <= '0;
      dropped_cnt_o <= '0;
    end else begin
      if (vinst_valid_o && vinst_ready_i && !flush_i) issued_cnt_o <= issued_cnt_o + CNT_W'(1);
      if (acc && !isv) dropped_cnt_o <= dropped_cnt_o + CNT_W'(1);
    end
endmodule
